addr_reducer: RTL and testbench
===============================

// Module: addr_reducer
// PURPOSE
//  Parametrised successor to the plain bit-truncating reducer: maps a DATA_WIDTH register value onto
//  an ADDR_WIDTH memory address under one of four run-time modes, flags out-of-range values, and
//  counts errors. Registered, one-deep valid/ready pipeline stage between the register file/ALU
//  result path and the data/instruction memory address ports.
// PARAMETERS
//  DATA_WIDTH  32    width of RDATA input
//  ADDR_WIDTH  11    width of ODATA output address
//  BASE_ADDR   0     DATA_WIDTH-bit base subtracted in OFFSET mode
//  LIMIT       2**ADDR_WIDTH-1  highest legal address; SATURATE clamps to it, others flag above it
//  CNT_WIDTH   16    width of ERRCNT
// PORTS
//  CLK     in   1           clock, all state updates on rising edge
//  RST     in   1           synchronous, active-high reset
//  MODE    in   2           00 TRUNC, 01 SAT, 10 OFFSET, 11 WORD; sampled with the input beat
//  IVALID  in   1           input beat valid
//  IREADY  out  1           stage can accept a beat
//  RDATA   in   DATA_WIDTH  register data to reduce
//  OVALID  out  1           ODATA/OERR valid
//  OREADY  in   1           consumer accepts output beat
//  ODATA   out  ADDR_WIDTH  reduced address
//  OERR    out  1           beat-aligned range/alignment error
//  ERRCLR  in   1           clear ERRCNT and STICKY
//  ERRCNT  out  CNT_WIDTH   saturating count of accepted beats with OERR=1
//  STICKY  out  1           set by first error beat, held until ERRCLR or RST
// BEHAVIOUR
//  Reset: OVALID=0, ODATA=0, OERR=0, ERRCNT=0, STICKY=0; IREADY=1 the cycle after RST deasserts.
//  Handshake: IREADY = !OVALID | OREADY (combinational). Accept when IVALID&IREADY; result on
//   ODATA/OERR/OVALID next cycle (latency 1). Output beat leaves when OVALID&OREADY. Accept+leave in
//   same cycle -> new beat replaces old, OVALID stays 1 (full throughput). OVALID&!OREADY -> ODATA,
//   OERR held stable, IREADY=0. IVALID ignored while IREADY=0.
//  Mapping (D=RDATA, A=ADDR_WIDTH):
//   TRUNC : ODATA=D[A-1:0];            OERR = |D[DATA_WIDTH-1:A] | (D[A-1:0] > LIMIT)
//   SAT   : ODATA = (D > LIMIT) ? LIMIT : D[A-1:0]; OERR = (D > LIMIT)  (unsigned compare)
//   OFFSET: T=D-BASE_ADDR (DATA_WIDTH, mod 2**DATA_WIDTH); ODATA=T[A-1:0];
//           OERR = (D < BASE_ADDR) | (T > LIMIT)
//   WORD  : ODATA=D[A+1:2] (byte->word address); OERR = |D[1:0] | |D[DATA_WIDTH-1:A+2]
//           | (D[A+1:2] > LIMIT)
//   ODATA always produced even when OERR=1 (consumer decides).
//  Counter: ERRCNT increments by 1 per accepted beat whose computed OERR=1; saturates at all-ones,
//   never wraps. STICKY set on same event. ERRCLR has priority over a same-cycle increment (result 0,
//   STICKY 0). ERRCLR does not affect pipeline state.
//  RST mid-operation: in-flight beat discarded (OVALID=0 next cycle); counter/sticky cleared.
//  MODE changes between beats take effect on the next accepted beat only.
// STRUCTURE
//  Package reducer_pkg: MODE_TRUNC/MODE_SAT/MODE_OFFSET/MODE_WORD 2-bit constants, mode typedef.
//  Sub-module addr_map (combinational: MODE, RDATA -> addr, err; same parameters); addr_reducer holds
//  pipeline register, handshake, ERRCNT/STICKY.
// TESTING (defaults unless noted)
//  1 TRUNC RDATA=0x0000_07FF then 0x0000_0800, OREADY=1 -> ODATA=0x7FF OERR=0; ODATA=0x000 OERR=1,
//    ERRCNT=1, STICKY=1, each one cycle after accept.
//  2 SAT RDATA=0x0001_2345 -> ODATA=0x7FF OERR=1; RDATA=0x123 -> ODATA=0x123 OERR=0.
//  3 OFFSET BASE_ADDR=0x1000: RDATA=0x1004 -> ODATA=0x004 OERR=0; RDATA=0x0FFC -> OERR=1.
//  4 WORD RDATA=0x0000_1FFC -> ODATA=0x7FF OERR=0; RDATA=0x0000_0006 -> ODATA=0x001 OERR=1.
//  5 Backpressure: OREADY=0 3 cycles with IVALID=1 -> IREADY=0, ODATA stable; OREADY=1 -> back-to-back
//    beats, one per cycle, no loss/duplication (scoreboard 100 random beats, random OREADY).
//  6 CNT_WIDTH=2: 5 error beats -> ERRCNT=3 held; ERRCLR with error beat same cycle -> ERRCNT=0;
//    RST with OVALID=1 -> OVALID=0 next cycle.

Source files
------------

// File: rtl/reducer_pkg.sv
// Shared mode encoding for the register-to-address reducer.
package reducer_pkg;

  typedef enum logic [1:0] {
    MODE_TRUNC  = 2'b00,
    MODE_SAT    = 2'b01,
    MODE_OFFSET = 2'b10,
    MODE_WORD   = 2'b11
  } mode_t;

endpackage

// File: rtl/addr_map.sv
// Combinational mapping of a register value onto a memory address plus range/alignment error.
// Address is always produced; err only advises the consumer.
module addr_map
  import reducer_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 11,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LIMIT      = 2**ADDR_WIDTH-1
) (
  input  mode_t                  mode,
  input  logic [DATA_WIDTH-1:0]  rdata,
  output logic [ADDR_WIDTH-1:0]  addr,
  output logic                   err
);

  localparam logic [DATA_WIDTH-1:0] LIM_D = DATA_WIDTH'(LIMIT);
  localparam logic [ADDR_WIDTH-1:0] LIM_A = ADDR_WIDTH'(LIMIT);

  logic [DATA_WIDTH-1:0] off;

  always_comb begin
    off  = rdata - BASE_ADDR;
    addr = '0;
    err  = 1'b0;
    unique case (mode)
      MODE_TRUNC: begin
        addr = rdata[ADDR_WIDTH-1:0];
        err  = ((rdata >> ADDR_WIDTH) != '0) | (DATA_WIDTH'(rdata[ADDR_WIDTH-1:0]) > LIM_D);
      end
      MODE_SAT: begin
        err  = rdata > LIM_D;
        addr = err ? LIM_A : rdata[ADDR_WIDTH-1:0];
      end
      MODE_OFFSET: begin
        // off wraps modulo 2**DATA_WIDTH, so underflow needs its own check
        addr = off[ADDR_WIDTH-1:0];
        err  = (rdata < BASE_ADDR) | (off > LIM_D);
      end
      MODE_WORD: begin
        addr = rdata[ADDR_WIDTH+1:2];
        err  = (rdata[1:0] != 2'b00) | ((rdata >> (ADDR_WIDTH + 2)) != '0)
             | (DATA_WIDTH'(rdata[ADDR_WIDTH+1:2]) > LIM_D);
      end
      default: begin
        addr = '0;
        err  = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/addr_reducer.sv
// One-deep registered valid/ready stage reducing register data to a memory address, latency 1.
// iready = !ovalid | oready, so a stalled output holds its beat and blocks input; errors counted.
module addr_reducer
  import reducer_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 11,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    LIMIT      = 2**ADDR_WIDTH-1,
  parameter int                    CNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             mode,
  input  logic                   ivalid,
  output logic                   iready,
  input  logic [DATA_WIDTH-1:0]  rdata,
  output logic                   ovalid,
  input  logic                   oready,
  output logic [ADDR_WIDTH-1:0]  odata,
  output logic                   oerr,
  input  logic                   errclr,
  output logic [CNT_WIDTH-1:0]   errcnt,
  output logic                   sticky
);

  logic [ADDR_WIDTH-1:0] map_addr;
  logic                  map_err;
  logic                  accept;

  addr_map #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BASE_ADDR  (BASE_ADDR),
    .LIMIT      (LIMIT)
  ) u_map (
    .mode  (mode_t'(mode)),
    .rdata (rdata),
    .addr  (map_addr),
    .err   (map_err)
  );

  assign iready = !ovalid | oready;
  assign accept = ivalid & iready;

  // Accept takes precedence over drain so a simultaneous leave+accept keeps ovalid high.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovalid <= 1'b0;
      odata  <= '0;
      oerr   <= 1'b0;
    end else if (accept) begin
      ovalid <= 1'b1;
      odata  <= map_addr;
      oerr   <= map_err;
    end else if (oready) begin
      ovalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || errclr) begin
      errcnt <= '0;
      sticky <= 1'b0;
    end else if (accept && map_err) begin
      if (errcnt != '1) errcnt <= errcnt + 1'b1;
      sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_addr_reducer.sv
// Bench for addr_reducer: default instance plus a BASE_ADDR=0x1000, CNT_WIDTH=2 instance on shared inputs.
module tb_addr_reducer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        ivalid;
  logic [31:0] rdata;
  logic        oready;
  logic        errclr;

  logic        iready0, ovalid0, oerr0, sticky0;
  logic [10:0] odata0;
  logic [15:0] errcnt0;
  logic        iready1, ovalid1, oerr1, sticky1;
  logic [10:0] odata1;
  logic [1:0]  errcnt1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  addr_reducer dut0 (
    .clk(clk), .rst(rst), .mode(mode), .ivalid(ivalid), .iready(iready0), .rdata(rdata),
    .ovalid(ovalid0), .oready(oready), .odata(odata0), .oerr(oerr0), .errclr(errclr),
    .errcnt(errcnt0), .sticky(sticky0)
  );

  addr_reducer #(.BASE_ADDR(32'h0000_1000), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .rst(rst), .mode(mode), .ivalid(ivalid), .iready(iready1), .rdata(rdata),
    .ovalid(ovalid1), .oready(oready), .odata(odata1), .oerr(oerr1), .errclr(errclr),
    .errcnt(errcnt1), .sticky(sticky1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference mapping in plain integer arithmetic on an 11-bit address space, LIMIT=2047.
  function automatic logic [11:0] ref_map(input logic [1:0] m, input logic [31:0] d_in,
                                          input longint base);
    longint d, a, t;
    bit e;
    d = d_in;
    a = 0;
    e = 0;
    case (m)
      2'd0: begin a = d % 2048; e = (d >= 2048); end
      2'd1: begin e = (d > 2047); a = e ? 2047 : d % 2048; end
      2'd2: begin
        t = d - base;
        if (t < 0) t = t + 64'h1_0000_0000;
        a = t % 2048;
        e = (d < base) || (t > 2047);
      end
      default: begin a = (d / 4) % 2048; e = (d % 4 != 0) || (d / 4 > 2047); end
    endcase
    return {e, a[10:0]};
  endfunction

  task automatic do_reset();
    rst = 1'b1; ivalid = 1'b0; errclr = 1'b0; oready = 1'b1; mode = 2'd0; rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [31:0] rdata;
    logic [10:0] a0;
    logic        e0;
    logic [10:0] a1;
    logic        e1;
  } vec_t;

  typedef struct {
    logic [10:0] a0;
    logic        e0;
    logic [10:0] a1;
    logic        e1;
  } exp_t;

  vec_t vt[10];
  exp_t sbq[$];
  int   m_cnt0, m_cnt1;
  bit   m_st0, m_st1;
  int   pushed, popped;

  // Negedge scoreboard step: outputs vs. queued expectations, then account for this cycle's handshake.
  task automatic sb_step();
    logic [11:0] r0, r1;
    exp_t e;
    chk("iready0", iready0, (sbq.size() == 0) || oready);
    chk("iready1", iready1, (sbq.size() == 0) || oready);
    chk("ovalid0", ovalid0, sbq.size() != 0);
    chk("ovalid1", ovalid1, sbq.size() != 0);
    chk("errcnt0", errcnt0, m_cnt0);
    chk("errcnt1", errcnt1, m_cnt1);
    chk("sticky0", sticky0, m_st0);
    chk("sticky1", sticky1, m_st1);
    if (sbq.size() != 0) begin
      chk("odata0", odata0, sbq[0].a0);
      chk("oerr0",  oerr0,  sbq[0].e0);
      chk("odata1", odata1, sbq[0].a1);
      chk("oerr1",  oerr1,  sbq[0].e1);
      if (oready) begin
        void'(sbq.pop_front());
        popped++;
      end
    end
    if (ivalid && iready0) begin
      r0 = ref_map(mode, rdata, 0);
      r1 = ref_map(mode, rdata, 64'h1000);
      e = '{r0[10:0], r0[11], r1[10:0], r1[11]};
      sbq.push_back(e);
      pushed++;
    end
    if (errclr) begin
      m_cnt0 = 0; m_cnt1 = 0; m_st0 = 0; m_st1 = 0;
    end else if (ivalid && iready0) begin
      if (r0[11]) begin m_st0 = 1; if (m_cnt0 < 65535) m_cnt0++; end
      if (r1[11]) begin m_st1 = 1; if (m_cnt1 < 3) m_cnt1++; end
    end
  endtask

  function automatic logic [31:0] rand_data();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return $urandom_range(0, 4095);
      2:       return 32'h0000_0FF0 + $urandom_range(0, 32'h0900);
      default: return $urandom_range(0, 8191);
    endcase
  endfunction

  initial begin
    int c0, c1, cyc;
    vt[0] = '{2'd0, 32'h0000_07FF, 11'h7FF, 1'b0, 11'h7FF, 1'b0};
    vt[1] = '{2'd0, 32'h0000_0800, 11'h000, 1'b1, 11'h000, 1'b1};
    vt[2] = '{2'd1, 32'h0001_2345, 11'h7FF, 1'b1, 11'h7FF, 1'b1};
    vt[3] = '{2'd1, 32'h0000_0123, 11'h123, 1'b0, 11'h123, 1'b0};
    vt[4] = '{2'd2, 32'h0000_1004, 11'h004, 1'b1, 11'h004, 1'b0};
    vt[5] = '{2'd2, 32'h0000_0FFC, 11'h7FC, 1'b1, 11'h7FC, 1'b1};
    vt[6] = '{2'd3, 32'h0000_1FFC, 11'h7FF, 1'b0, 11'h7FF, 1'b0};
    vt[7] = '{2'd3, 32'h0000_0006, 11'h001, 1'b1, 11'h001, 1'b1};
    vt[8] = '{2'd2, 32'h0000_17FF, 11'h7FF, 1'b1, 11'h7FF, 1'b0};
    vt[9] = '{2'd3, 32'h0000_2000, 11'h000, 1'b1, 11'h000, 1'b1};

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_ovalid", ovalid0, 0);
    chk("rst_odata",  odata0,  0);
    chk("rst_oerr",   oerr0,   0);
    chk("rst_errcnt", errcnt0, 0);
    chk("rst_sticky", sticky0, 0);
    chk("rst_iready", iready0, 1);

    // Directed vectors, one beat at a time, OREADY=1
    c0 = 0; c1 = 0;
    foreach (vt[i]) begin
      @(posedge clk); #1;
      mode = vt[i].mode; rdata = vt[i].rdata; ivalid = 1'b1; oready = 1'b1;
      @(posedge clk); #1;
      ivalid = 1'b0;
      if (vt[i].e0) c0++;
      if (vt[i].e1 && c1 < 3) c1++;
      @(negedge clk);
      chk($sformatf("vec%0d_ovalid", i), ovalid0, 1);
      chk($sformatf("vec%0d_odata0", i), odata0, vt[i].a0);
      chk($sformatf("vec%0d_oerr0", i),  oerr0,  vt[i].e0);
      chk($sformatf("vec%0d_odata1", i), odata1, vt[i].a1);
      chk($sformatf("vec%0d_oerr1", i),  oerr1,  vt[i].e1);
      chk($sformatf("vec%0d_errcnt0", i), errcnt0, c0);
      chk($sformatf("vec%0d_errcnt1", i), errcnt1, c1);
      chk($sformatf("vec%0d_sticky0", i), sticky0, c0 != 0);
    end
    chk("errcnt1_saturated", errcnt1, 3);

    // Backpressure: held output, blocked input, then replace on release
    do_reset();
    mode = 2'd0; rdata = 32'h0000_0911; ivalid = 1'b1; oready = 1'b0;
    @(posedge clk); #1;
    rdata = 32'h0000_0222;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_iready", iready0, 0);
      chk("bp_ovalid", ovalid0, 1);
      chk("bp_odata",  odata0,  11'h111);
      chk("bp_oerr",   oerr0,   1);
      @(posedge clk); #1;
    end
    oready = 1'b1;
    @(negedge clk);
    chk("bp_release_iready", iready0, 1);
    @(posedge clk); #1;
    ivalid = 1'b0;
    @(negedge clk);
    chk("bp_next_ovalid", ovalid0, 1);
    chk("bp_next_odata",  odata0,  11'h222);
    chk("bp_errcnt",      errcnt0, 1);

    // ERRCLR wins over a same-cycle error beat; pipeline still carries the beat
    @(posedge clk); #1;
    rdata = 32'h0000_0800; ivalid = 1'b1; errclr = 1'b1;
    @(posedge clk); #1;
    ivalid = 1'b0; errclr = 1'b0; oready = 1'b0;
    @(negedge clk);
    chk("clr_errcnt0", errcnt0, 0);
    chk("clr_errcnt1", errcnt1, 0);
    chk("clr_sticky",  sticky0, 0);
    chk("clr_ovalid",  ovalid0, 1);
    chk("clr_oerr",    oerr0,   1);

    // Reset while a beat is held
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("prerst_ovalid", ovalid0, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ovalid", ovalid0, 0);
    chk("midrst_ovalid1", ovalid1, 0);

    // Randomized traffic against the scoreboard
    do_reset();
    sbq.delete();
    m_cnt0 = 0; m_cnt1 = 0; m_st0 = 0; m_st1 = 0;
    pushed = 0; popped = 0; cyc = 0;
    @(negedge clk);
    while (pushed < 100 && cyc < 3000) begin
      @(posedge clk); #1;
      ivalid = ($urandom_range(0, 3) != 0);
      oready = ($urandom_range(0, 2) != 0);
      mode   = 2'($urandom_range(0, 3));
      rdata  = rand_data();
      errclr = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      sb_step();
      cyc++;
    end
    chk("rand_beats_sent", pushed >= 100, 1);
    @(posedge clk); #1;
    ivalid = 1'b0; oready = 1'b1; errclr = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sb_step();
      @(posedge clk); #1;
    end
    chk("rand_drained", sbq.size(), 0);
    chk("rand_no_loss", popped, pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
